// File: rtl/mdu_if.sv
// Handshake/data bundle between the E-stage operand path and the multiply/divide unit.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side drives operands/op/strobe and observes status and HI/LO.
    modport master (output A, B, MDOp, Start, input Busy, HI, LO);
    // Unit side consumes operands/op/strobe and presents status and HI/LO.
    modport slave  (input A, B, MDOp, Start, output Busy, HI, LO);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at the Start edge into pending registers and committed
// to HI/LO only when the latency counter expires.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus
);
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  count;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi, pend_lo;

    logic [31:0] res_hi, res_lo;
    logic        is_long_op;
    logic [3:0]  load_val;

    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg, b_neg, div_zero;
    logic [31:0] a_mag, b_mag, divisor, uq, ur, sq, sr;

    // Full-result datapath for mult/multu/div/divu from the current operands.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        res_hi     = hi_q;
        res_lo     = lo_q;
        is_long_op = 1'b0;
        load_val   = 4'd0;

        prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
        prod_u = {32'b0, bus.A} * {32'b0, bus.B};

        // Signed divide is done on magnitudes so truncation toward zero and the
        // remainder-follows-dividend rule are explicit; 0x80000000 / -1 falls out
        // as 0x80000000 with remainder 0 because negation wraps.
        div_zero = (bus.B == 32'd0);
        a_neg    = (bus.MDOp == OP_DIV) && bus.A[31];
        b_neg    = (bus.MDOp == OP_DIV) && bus.B[31];
        a_mag    = a_neg ? (~bus.A + 32'd1) : bus.A;
        b_mag    = b_neg ? (~bus.B + 32'd1) : bus.B;
        divisor  = div_zero ? 32'd1 : b_mag;
        uq       = a_mag / divisor;
        ur       = a_mag % divisor;
        sq       = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        sr       = a_neg ? (~ur + 32'd1) : ur;

        case (bus.MDOp)
            OP_MULT: begin
                res_hi     = prod_s[63:32];
                res_lo     = prod_s[31:0];
                is_long_op = 1'b1;
                load_val   = MULT_LOAD;
            end
            OP_MULTU: begin
                res_hi     = prod_u[63:32];
                res_lo     = prod_u[31:0];
                is_long_op = 1'b1;
                load_val   = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
                // Divide by zero commits the current HI/LO, i.e. leaves them untouched.
                if (!div_zero) begin
                    res_hi = sr;
                    res_lo = sq;
                end
                is_long_op = 1'b1;
                load_val   = DIV_LOAD;
            end
            default: ;
        endcase
    end

    // Latency counter, pending result capture, commit and mthi/mtlo writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: pending registers are reset too so a discarded operation leaves nothing behind.
            count   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (busy_q) begin
            // NOTE: non-blocking assignments keep every register update tied to the same edge.
            count <= count - 4'd1;
            if (count == 4'd1) begin
                hi_q   <= pend_hi;
                lo_q   <= pend_lo;
                busy_q <= 1'b0;
            end
        end else if (bus.Start) begin
            if (is_long_op) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                count   <= load_val;
                busy_q  <= 1'b1;
            end else if (bus.MDOp == OP_MTHI) begin
                hi_q <= bus.A;
            end else if (bus.MDOp == OP_MTLO) begin
                lo_q <= bus.A;
            end
        end
    end

    assign bus.Busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for the multiply/divide unit.
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mdu_if bus ();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives a one-cycle Start pulse across the next posedge.
    task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.MDOp  = OP_NONE;
    endtask

    // Runs a long op, checking Busy and frozen HI/LO every cycle, then the committed result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] prev_hi, prev_lo;
        prev_hi = bus.HI;
        prev_lo = bus.LO;
        pulse(op, a, b);
        bus.A = 32'hA5A5_5A5A;
        bus.B = 32'h0F0F_F0F0;
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, {31'd0, bus.Busy}, 32'd1);
            check({tag, " hi held"}, bus.HI, prev_hi);
            check({tag, " lo held"}, bus.LO, prev_lo);
            @(negedge clk);
        end
        check({tag, " busy done"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, " hi"}, bus.HI, exp_hi);
        check({tag, " lo"}, bus.LO, exp_lo);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.MDOp  = OP_NONE;
        bus.Start = 1'b0;
        reset     = 1'b1;
        #1;
        check("reset busy", {31'd0, bus.Busy}, 32'd0);
        check("reset hi", bus.HI, 32'd0);
        check("reset lo", bus.LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult -2*3", OP_MULT, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu ff*ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult ff*ff", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'h0000_0000, 32'h0000_0001);
        run_op("mult big", OP_MULT, 32'h1234_5678, 32'h0000_0010, MC, 32'h0000_0001, 32'h2345_6780);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", OP_DIVU, 32'd7, 32'd2, DC, 32'd1, 32'd3);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000);
        run_op("divu ff/2", OP_DIVU, 32'hFFFF_FFFF, 32'd2, DC, 32'd1, 32'h7FFF_FFFF);

        // mthi/mtlo land after the sampling edge with no busy period.
        pulse(OP_MTHI, 32'h11, 32'd0);
        check("mthi busy", {31'd0, bus.Busy}, 32'd0);
        check("mthi hi", bus.HI, 32'h11);
        pulse(OP_MTLO, 32'h22, 32'd0);
        check("mtlo busy", {31'd0, bus.Busy}, 32'd0);
        check("mtlo lo", bus.LO, 32'h22);
        check("mtlo hi kept", bus.HI, 32'h11);

        run_op("div x/0", OP_DIV, 32'h1234, 32'd0, DC, 32'h11, 32'h22);
        run_op("divu x/0", OP_DIVU, 32'hFFFF_FFFF, 32'd0, DC, 32'h11, 32'h22);

        pulse(OP_MTHI, 32'hDEAD, 32'd0);
        check("mthi dead busy", {31'd0, bus.Busy}, 32'd0);
        check("mthi dead hi", bus.HI, 32'hDEAD);

        // MDOp none and reserved must not touch anything.
        pulse(OP_NONE, 32'h5555, 32'h6666);
        check("op0 busy", {31'd0, bus.Busy}, 32'd0);
        check("op0 hi", bus.HI, 32'hDEAD);
        check("op0 lo", bus.LO, 32'h22);
        pulse(OP_RSVD, 32'h5555, 32'h6666);
        check("op7 busy", {31'd0, bus.Busy}, 32'd0);
        check("op7 hi", bus.HI, 32'hDEAD);
        check("op7 lo", bus.LO, 32'h22);

        // Start while busy: mtlo and a second mult are both dropped.
        pulse(OP_MULT, 32'd5, 32'd7);
        pulse(OP_MTLO, 32'h1234, 32'd0);
        check("sb mtlo ignored", bus.LO, 32'h22);
        check("sb busy", {31'd0, bus.Busy}, 32'd1);
        pulse(OP_MULT, 32'd100, 32'd100);
        check("sb mult ignored", bus.LO, 32'h22);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("sb busy done", {31'd0, bus.Busy}, 32'd0);
        check("sb hi", bus.HI, 32'd0);
        check("sb lo", bus.LO, 32'd35);

        // Back-to-back: next op is accepted in the first idle cycle.
        run_op("b2b divu", OP_DIVU, 32'd100, 32'd7, DC, 32'd2, 32'd14);
        run_op("b2b multu", OP_MULTU, 32'h8000_0000, 32'd4, MC, 32'd2, 32'd0);

        // Reset during a divide clears immediately and nothing commits later.
        pulse(OP_MTLO, 32'h77, 32'd0);
        pulse(OP_DIVU, 32'd9, 32'd3);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst mid busy", {31'd0, bus.Busy}, 32'd0);
        check("rst mid hi", bus.HI, 32'd0);
        check("rst mid lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DC + 2; i++) @(negedge clk);
        check("rst after busy", {31'd0, bus.Busy}, 32'd0);
        check("rst after hi", bus.HI, 32'd0);
        check("rst after lo", bus.LO, 32'd0);

        run_op("post rst mult", OP_MULT, 32'hFFFF_FFFF, 32'd1, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage, directly downstream of the E-stage forwarding mux: it takes the two forwarded operands (rs/rt after bypass) and runs mult, multu, div and divu over a fixed multi-cycle latency. It also executes mthi/mtlo and holds the architectural HI/LO registers. Busy goes to the hazard unit, which stalls any mult/div/mfhi/mflo/mthi/mtlo in D while `Start | Busy` is high.

## Interface
- `MULT_CYCLES`, default 5: cycles Busy stays high for mult/multu (legal range 1..15).
- `DIV_CYCLES`, default 10: cycles Busy stays high for div/divu (legal range 1..15).

Ports:
- `clk` input, 1: the single clock; all state changes on its rising edge.
- `reset` input, 1: asynchronous, active-high; clears all state immediately.
- `A` input, 32: forwarded rs operand (dividend / multiplicand / mthi-mtlo data).
- `B` input, 32: forwarded rt operand (divisor / multiplier).
- `MDOp` input, 3: operation select. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `Start` input, 1: one-cycle strobe. When high, MDOp is valid for the instruction currently in E.
- `Busy` output, 1: a mult/div operation is in flight.
- `HI` output, 32: architectural HI register.
- `LO` output, 32: architectural LO register.

## Operation
- **Reset (async):**
  - HI = 0, LO = 0, Busy = 0.
  - Cycle counter = 0 and the pending-result registers are cleared.
  - Any in-flight operation is discarded and never committed.
- **Idle:** Busy = 0, counter = 0.
- **Start with a mult/div op while idle:** at that edge:
  - Compute the full result into the pending registers `PendHI`/`PendLO`.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set Busy = 1.
- **Running:** the counter decrements each edge. On the edge where it goes 1→0:
  - HI ← PendHI, LO ← PendLO.
  - Busy ← 0.
- **Start with mthi/mtlo while idle:** HI ← A (or LO ← A) at that edge. Busy stays 0 and there is no latency.
- **Start while Busy = 1:** ignored entirely. The hazard unit guarantees it does not happen; the RTL must still not corrupt state.
- **Start with MDOp 0 or 7:** no effect.
- **Arithmetic rules:**
  - mult: signed 32×32 → 64; HI = bits 63:32, LO = bits 31:0.
  - multu: same split, unsigned operands.
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - div edge case: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - divu: unsigned quotient and remainder.
- **Divide by zero (B = 0, div or divu):** Busy still runs the full DIV_CYCLES. At completion HI/LO keep their prior values (PendHI/PendLO are loaded with the current HI/LO).
- HI/LO never change on any edge other than a completion edge, an mthi/mtlo edge, or reset.

## Timing
- Latency:
  - Start sampled at edge k → Busy high from edge k through edge k+N.
  - Busy = 1 for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - The new HI/LO are visible after edge k+N.
- Busy, HI and LO are registered outputs with no combinational path from any input.
- mthi/mtlo: the new value is visible after the same edge that samples Start.
- Back-to-back: a new Start is accepted in the first cycle with Busy = 0, i.e. the cycle right after the completion edge.
- A and B are sampled only at the Start edge; later changes on them are ignored.
- Reset asserted mid-operation: Busy drops to 0 and HI/LO go to 0 without waiting for a clock edge. After release the block is idle.

## Test plan
- **Reset:** after reset, HI = LO = 0 and Busy = 0. Assert reset at cycle 3 of a div → Busy = 0 and HI = LO = 0 at once, and no commit occurs later.
- **Signed mult:** mult A = 0xFFFFFFFE (−2), B = 3, Start at edge k.
  - Busy high for 5 cycles.
  - After edge k+5: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - HI/LO unchanged at edges k..k+4.
- **multu vs mult:** multu 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. The same operands with mult → HI = 0, LO = 1.
- **Signed div:**
  - div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, Busy high for 10 cycles.
  - divu 7 / 2 → LO = 3, HI = 1.
  - div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** with HI = 0x11, LO = 0x22, run div X / 0 → Busy high for 10 cycles, and HI/LO are still 0x11/0x22 afterwards.
- **mthi/mtlo and start-while-busy:**
  - mthi A = 0xDEAD → HI = 0xDEAD the next cycle with Busy = 0.
  - Start an mtlo while a mult is busy → ignored; LO receives only the mult result at completion.
